// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the user GPIO bank: register offsets inside the
// 256 B Wishbone window, reset constants and the byte-lane merge helper.
package gpio_bank_pkg;

    // Register offsets (byte addresses relative to the bank base)
    localparam logic [7:0] OFS_DATA_OUT = 8'h00;
    localparam logic [7:0] OFS_OEB      = 8'h04;
    localparam logic [7:0] OFS_DATA_IN  = 8'h08;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h0C;
    localparam logic [7:0] OFS_IRQ_STAT = 8'h10;
    localparam logic [7:0] OFS_EDGE_SEL = 8'h14;

    // Reset constants (only the low N_IO bits are used)
    localparam logic [31:0] RST_OEB      = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_IRQ_EN   = 32'h0000_0000;
    localparam logic [31:0] RST_IRQ_STAT = 32'h0000_0000;
    localparam logic [31:0] RST_EDGE_SEL = 32'h0000_0000;

    // Cycles after reset release during which edges are ignored, so the
    // synchroniser filling up from its reset value raises no interrupt.
    localparam int unsigned EDGE_SETTLE_CYC = 3;

    // Replace the bytes of old_val selected by sel with those of new_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// One GPIO input channel: 2-flop synchroniser, optional debounce filter,
// history flop and rising/falling edge detector.
// Optional feature macro: GPIO_DEBOUNCE_EN (adds an 8-bit stability counter).
module gpio_in_chan
    import gpio_bank_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    input  logic edge_sel,
    output logic level,
    output logic edge_det
);

    logic sync1_r;
    logic sync2_r;
    logic hist_r;
    logic level_s;

    // Two-flop synchroniser for the asynchronous pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pad;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [7:0] cnt_r;
    logic       acc_r;

    // Accept a new level only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
            acc_r <= 1'b0;
        end else if (sync2_r == acc_r) begin
            cnt_r <= 8'd0;
            acc_r <= acc_r;
        end else if (cnt_r == 8'(DEBOUNCE_CYC - 1)) begin
            cnt_r <= 8'd0;
            acc_r <= sync2_r;
        end else begin
            cnt_r <= cnt_r + 8'd1;
            acc_r <= acc_r;
        end
    end

    assign level_s = acc_r;
`else
    assign level_s = sync2_r;
`endif

    // History flop: the accepted level one cycle earlier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 1'b0;
        end else begin
            hist_r <= level_s;
        end
    end

    // Edge detector: edge_sel=0 picks rising, edge_sel=1 picks falling
    always_comb begin
        edge_det = 1'b0;
        if (edge_sel) begin
            edge_det = hist_r & ~level_s;
        end else begin
            edge_det = level_s & ~hist_r;
        end
    end

    assign level = level_s;

endmodule

// File: rtl/user_gpio_bank.sv
// Wishbone-mapped GPIO bank: per-pin output data, direction, synchronised
// input sampling and edge interrupts with a level irq_o.
// Optional feature macro: GPIO_DEBOUNCE_EN (per-channel input debounce).
module user_gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned N_IO         = 16,
    parameter logic [31:0] ADDR_BASE    = 32'h3000_0000,
    parameter logic [31:0] RST_OUT      = 32'h0000_0000,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic [31:0]     wbs_dat_o,
    output logic            wbs_ack_o,
    input  logic [N_IO-1:0] io_in,
    output logic [N_IO-1:0] io_out,
    output logic [N_IO-1:0] io_oeb,
    output logic            irq_o
);

`ifdef GPIO_DEBOUNCE_EN
    // The debounce filter delays the first accepted level as well
    localparam int unsigned SETTLE_CYC = EDGE_SETTLE_CYC + DEBOUNCE_CYC;
`else
    localparam int unsigned SETTLE_CYC = EDGE_SETTLE_CYC;
`endif

    logic [N_IO-1:0] data_out_r;
    logic [N_IO-1:0] oeb_r;
    logic [N_IO-1:0] irq_en_r;
    logic [N_IO-1:0] irq_stat_r;
    logic [N_IO-1:0] edge_sel_r;
    logic [N_IO-1:0] level_vec_s;
    logic [N_IO-1:0] edge_vec_s;
    logic [N_IO-1:0] stat_set_s;
    logic [N_IO-1:0] stat_clr_s;
    logic            ack_r;
    logic [31:0]     dat_r;
    logic            irq_r;
    logic [8:0]      settle_r;
    logic            edge_en_s;
    logic            sel_s;
    logic            access_s;
    logic            wr_s;
    logic            rd_s;
    logic [7:0]      ofs_s;
    logic [31:0]     rdata_s;
    logic [31:0]     merged_s;
    logic [31:0]     w1c_s;

    // Input channels
    for (genvar i = 0; i < int'(N_IO); i++) begin : g_chan
        gpio_in_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_chan (
            .clk      (wb_clk_i),
            .rst_n    (wb_rst_ni),
            .pad      (io_in[i]),
            .edge_sel (edge_sel_r[i]),
            .level    (level_vec_s[i]),
            .edge_det (edge_vec_s[i])
        );
    end

    // Bus decode; a new access is only taken when no ack is pending, so ack
    // can never be high on two consecutive cycles.
    assign sel_s    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign ofs_s    = wbs_adr_i[7:0];
    assign access_s = sel_s & ~ack_r;
    assign wr_s     = access_s & wbs_we_i;
    assign rd_s     = access_s & ~wbs_we_i;

    // Read multiplexer; unmapped offsets and bits above N_IO read as zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (ofs_s)
            OFS_DATA_OUT: rdata_s[N_IO-1:0] = data_out_r;
            OFS_OEB:      rdata_s[N_IO-1:0] = oeb_r;
            OFS_DATA_IN:  rdata_s[N_IO-1:0] = level_vec_s;
            OFS_IRQ_EN:   rdata_s[N_IO-1:0] = irq_en_r;
            OFS_IRQ_STAT: rdata_s[N_IO-1:0] = irq_stat_r;
            OFS_EDGE_SEL: rdata_s[N_IO-1:0] = edge_sel_r;
            default:      rdata_s = 32'h0000_0000;
        endcase
    end

    assign merged_s = byte_merge(rdata_s, wbs_dat_i, wbs_sel_i);
    assign w1c_s    = byte_merge(32'h0000_0000, wbs_dat_i, wbs_sel_i);

    // Ack pulse and registered read data (zero whenever no read is acked)
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= access_s;
            dat_r <= rd_s ? rdata_s : 32'h0000_0000;
        end
    end

    // Read/write control registers, committed on the edge that raises ack
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            data_out_r <= RST_OUT[N_IO-1:0];
            oeb_r      <= RST_OEB[N_IO-1:0];
            irq_en_r   <= RST_IRQ_EN[N_IO-1:0];
            edge_sel_r <= RST_EDGE_SEL[N_IO-1:0];
        end else if (wr_s) begin
            case (ofs_s)
                OFS_DATA_OUT: data_out_r <= merged_s[N_IO-1:0];
                OFS_OEB:      oeb_r      <= merged_s[N_IO-1:0];
                OFS_IRQ_EN:   irq_en_r   <= merged_s[N_IO-1:0];
                OFS_EDGE_SEL: edge_sel_r <= merged_s[N_IO-1:0];
                default:      data_out_r <= data_out_r;
            endcase
        end else begin
            data_out_r <= data_out_r;
        end
    end

    // Post-reset settle counter gating edge detection
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            settle_r <= 9'd0;
        end else if (!edge_en_s) begin
            settle_r <= settle_r + 9'd1;
        end else begin
            settle_r <= settle_r;
        end
    end

    assign edge_en_s = (settle_r == 9'(SETTLE_CYC));

    // Status set/clear terms; a set always overrides a same-cycle clear
    always_comb begin
        stat_set_s = '0;
        stat_clr_s = '0;
        if (edge_en_s) begin
            stat_set_s = edge_vec_s;
        end else begin
            stat_set_s = '0;
        end
        if (wr_s && (ofs_s == OFS_IRQ_STAT)) begin
            stat_clr_s = w1c_s[N_IO-1:0];
        end else begin
            stat_clr_s = '0;
        end
    end

    // Interrupt status register and registered level interrupt
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_stat_r <= RST_IRQ_STAT[N_IO-1:0];
            irq_r      <= 1'b0;
        end else begin
            irq_stat_r <= (irq_stat_r & ~stat_clr_s) | stat_set_s;
            irq_r      <= |(irq_stat_r & irq_en_r);
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign irq_o     = irq_r;
    assign io_out    = data_out_r;
    assign io_oeb    = oeb_r;

endmodule

// File: tb/tb_user_gpio_bank.sv
// Self-checking bench for user_gpio_bank (default parameters): directed
// register/edge/timing steps followed by randomised register and pad traffic
// checked against a simple register-map model.
module tb_user_gpio_bank;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'h0000_FFFF;

    logic          clk;
    logic          rst_n;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [3:0]    sel;
    logic [31:0]   adr;
    logic [31:0]   dat;
    logic [31:0]   dat_o;
    logic          ack_o;
    logic [N-1:0]  io_in;
    logic [N-1:0]  io_out;
    logic [N-1:0]  io_oeb;
    logic          irq_o;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   rd;
    logic          ak;
    logic [31:0]   m_reg [4];
    logic [7:0]    ofs_tab [4];
    logic [31:0]   pad_q;
    logic [31:0]   pad_n;
    logic [31:0]   exp_stat;

    user_gpio_bank dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_dat_o (dat_o),
        .wbs_ack_o (ack_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // One bus transfer; stb stays up one cycle past ack to prove ack is a pulse
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output logic acked);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        acked = 1'b0;
        r = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (ack_o) begin
                acked = 1'b1;
                r = dat_o;
                break;
            end
        end
        if (acked) begin
            @(posedge clk);
            #1;
            check("ack_single_cycle", {31'b0, ack_o}, 32'h0);
            check("dat_idle_zero", dat_o, 32'h0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wb_write(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic        a;
        wb_xfer(1'b1, BASE + {24'h0, o}, d, s, r, a);
        check("write_ack", {31'b0, a}, 32'h1);
    endtask

    task automatic wb_read(input logic [7:0] o, output logic [31:0] r);
        logic a;
        wb_xfer(1'b0, BASE + {24'h0, o}, 32'h0, 4'hF, r, a);
        check("read_ack", {31'b0, a}, 32'h1);
    endtask

    initial begin
        ofs_tab = '{8'h00, 8'h04, 8'h0C, 8'h14};
        m_reg   = '{32'h0, 32'h0000_FFFF, 32'h0, 32'h0};
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat = 32'h0; io_in = '0;

        // Reset state
        cycles(3);
        check("rst_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        check("rst_io_out", {16'h0, io_out}, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        check("rst_ack", {31'b0, ack_o}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        rst_n = 1'b1;
        cycles(4);
        wb_read(8'h00, rd); check("rst_data_out", rd, 32'h0);
        wb_read(8'h04, rd); check("rst_oeb", rd, 32'h0000_FFFF);
        wb_read(8'h08, rd); check("rst_data_in", rd, 32'h0);
        wb_read(8'h0C, rd); check("rst_irq_en", rd, 32'h0);
        wb_read(8'h10, rd); check("rst_irq_stat", rd, 32'h0);
        wb_read(8'h14, rd); check("rst_edge_sel", rd, 32'h0);

        // Byte-lane write
        wb_write(8'h00, 32'hA5A5, 4'b0001);
        check("io_out_after_ack", {16'h0, io_out}, 32'h0000_00A5);
        wb_read(8'h00, rd); check("data_out_sel", rd, 32'h0000_00A5);
        m_reg[0] = 32'h0000_00A5;

        // Rising edge on bit 3: DATA_IN latency 2, irq_o after 4 cycles
        wb_write(8'h0C, 32'h0000_0008, 4'hF);
        m_reg[2] = 32'h0000_0008;
        io_in[3] = 1'b1;
        cycles(2);
        wb_read(8'h08, rd); check("data_in_rise_lat2", rd, 32'h0000_0008);
        check("irq_after_4", {31'b0, irq_o}, 32'h1);
        wb_read(8'h10, rd); check("stat_bit3", rd, 32'h0000_0008);
        wb_write(8'h10, 32'h0000_0008, 4'hF);
        check("irq_cleared", {31'b0, irq_o}, 32'h0);
        wb_read(8'h10, rd); check("stat_cleared", rd, 32'h0);
        // Falling bit 3: still old value 1 cycle after change, new after 3
        io_in[3] = 1'b0;
        cycles(1);
        wb_read(8'h08, rd); check("data_in_not_early", rd, 32'h0000_0008);
        wb_read(8'h08, rd); check("data_in_fall", rd, 32'h0);
        wb_read(8'h10, rd); check("fall_no_stat_rising_mode", rd, 32'h0);

        // Falling-edge select on bit 0
        wb_write(8'h14, 32'h0000_0001, 4'hF);
        io_in[0] = 1'b1; cycles(5);
        wb_read(8'h10, rd); check("es_rise_ignored", rd, 32'h0);
        io_in[0] = 1'b0; cycles(5);
        wb_read(8'h10, rd); check("es_fall_sets", rd, 32'h0000_0001);
        wb_write(8'h10, 32'h0000_0001, 4'hF);
        io_in[0] = 1'b1; cycles(5);
        wb_read(8'h10, rd); check("es_rise_ignored2", rd, 32'h0);
        check("irq_masked_bit0", {31'b0, irq_o}, 32'h0);

        // Set wins over same-cycle W1C on bit 5
        wb_write(8'h14, 32'h0, 4'hF);
        io_in[5] = 1'b1;
        cycles(2);
        wb_write(8'h10, 32'h0000_0020, 4'hF);
        wb_read(8'h10, rd); check("set_beats_w1c", rd, 32'h0000_0020);
        wb_write(8'h10, 32'h0000_0020, 4'hF);
        wb_read(8'h10, rd); check("w1c_bit5", rd, 32'h0);
        pad_q = {16'h0, io_in};

        // Unmapped offset and out-of-window address
        wb_xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, rd, ak);
        check("unmapped_ack", {31'b0, ak}, 32'h1);
        check("unmapped_data", rd, 32'h0);
        wb_xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, rd, ak);
        wb_read(8'h00, rd); check("unmapped_write_discard", rd, 32'h0000_00A5);
        wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, ak);
        check("out_of_window_noack", {31'b0, ak}, 32'h0);

        // Random register traffic against the model
        for (int it = 0; it < 24; it++) begin
            int          k;
            logic [31:0] d;
            logic [3:0]  s;
            k = $urandom_range(0, 3);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            wb_write(ofs_tab[k], d, s);
            m_reg[k] = ((m_reg[k] & ~lane_mask(s)) | (d & lane_mask(s))) & MASK;
            wb_read(ofs_tab[k], rd); check("rand_reg", rd, m_reg[k]);
            check("rand_io_out", {16'h0, io_out}, m_reg[0]);
            check("rand_io_oeb", {16'h0, io_oeb}, m_reg[1]);
        end

        // Random pad patterns: edges per bit follow EDGE_SEL
        for (int it = 0; it < 12; it++) begin
            wb_write(8'h10, 32'hFFFF_FFFF, 4'hF);
            pad_n = $urandom & MASK;
            io_in = pad_n[N-1:0];
            cycles(6);
            exp_stat = ((pad_n & ~pad_q & ~m_reg[3]) | (~pad_n & pad_q & m_reg[3])) & MASK;
            wb_read(8'h08, rd); check("rand_data_in", rd, pad_n);
            wb_read(8'h10, rd); check("rand_stat", rd, exp_stat);
            check("rand_irq", {31'b0, irq_o}, {31'b0, |(exp_stat & m_reg[2])});
            pad_q = pad_n;
        end

        // Reset during an acked write, with all pads high while leaving reset
        io_in = '1;
        cycles(6);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat = 32'h1234; sel = 4'hF;
        cycles(1);
        check("ack_before_reset", {31'b0, ack_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("reset_kills_ack", {31'b0, ack_o}, 32'h0);
        check("reset_io_out", {16'h0, io_out}, 32'h0);
        check("reset_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        cycles(2);
        rst_n = 1'b1;
        cycles(8);
        wb_read(8'h10, rd); check("settle_no_irq", rd, 32'h0);
        wb_read(8'h08, rd); check("settle_data_in", rd, 32'h0000_FFFF);
        wb_read(8'h00, rd); check("aborted_write", rd, 32'h0);
        wb_read(8'h04, rd); check("post_rst_oeb", rd, 32'h0000_FFFF);
        check("post_rst_irq", {31'b0, irq_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
